// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ clients.
// Latches the winner's word, pulses tx_ena, and tracks the frame via tx_busy.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int D_WIDTH     = 15,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]           grant,
    output logic                       tx_ena,
    output logic [D_WIDTH-1:0]         tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic                       busy,
    output logic                       done,
    output logic                       ack_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t state, state_n;

    logic [ID_W-1:0]  last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] grant_n;
    logic             tx_ena_n;
    logic [D_WIDTH-1:0] tx_data_n;
    logic [ID_W-1:0]  id_n;
    logic             busy_n, done_n, ack_err_n;

    logic [N_REQ-1:0][D_WIDTH-1:0] words;
    logic [ID_W-1:0]  win;
    logic             win_ok;
    logic             can_grant;
    logic             ack_expired;

    assign words       = req_data;
    assign can_grant   = win_ok && !tx_busy;
    assign ack_expired = (cnt == CNT_W'(ACK_TIMEOUT));

    function automatic logic [ID_W-1:0] rr_idx(
        input logic [ID_W-1:0] base,
        input int              k
    );
        int s;
        s = (int'(base) + k) % N_REQ;
        return s[ID_W-1:0];
    endfunction

    // Cyclic search starting just after the last winner.
    always_comb begin
        win    = last;
        win_ok = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_ok && req[rr_idx(last, k)]) begin
                win_ok = 1'b1;
                win    = rr_idx(last, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(N_REQ - 1);
            cnt       <= '0;
            grant     <= '0;
            tx_ena    <= 1'b0;
            tx_data   <= '0;
            active_id <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            cnt       <= cnt_n;
            grant     <= grant_n;
            tx_ena    <= tx_ena_n;
            tx_data   <= tx_data_n;
            active_id <= id_n;
            busy      <= busy_n;
            done      <= done_n;
            ack_err   <= ack_err_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (can_grant) state_n = ISSUE;
            end
            ISSUE: state_n = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy)          state_n = WAIT_DONE;
                else if (ack_expired) state_n = IDLE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_n   = '0;
        tx_ena_n  = 1'b0;
        done_n    = 1'b0;
        ack_err_n = 1'b0;
        tx_data_n = tx_data;
        id_n      = active_id;
        last_n    = last;
        busy_n    = busy;
        cnt_n     = cnt;
        unique case (state)
            IDLE: begin
                if (can_grant) begin
                    grant_n[win] = 1'b1;
                    tx_ena_n     = 1'b1;
                    tx_data_n    = words[win];
                    id_n         = win;
                    last_n       = win;
                    busy_n       = 1'b1;
                end
            end
            ISSUE: cnt_n = '0;
            WAIT_ACK: begin
                // Timed-out words are dropped; no retry.
                if (!tx_busy) begin
                    if (ack_expired) begin
                        ack_err_n = 1'b1;
                        busy_n    = 1'b0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scoreboard of expected grants
// and a simple transmitter model that holds tx_busy for FRAME cycles.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 15;
    localparam int T     = 4;
    localparam int FRAME = 5;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [DW-1:0] d;
        logic [1:0]    id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic            tx_ena;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic [1:0]      active_id;
    logic            busy, done, ack_err;

    logic [DW-1:0] w [N];
    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bcnt = 0;
    logic model_en;
    logic force_busy;
    int g_cyc = 0, d_cyc = 0, a_cyc = 0;
    int n_ena = 0, n_done = 0, n_err = 0;
    int last_ena = -1;
    logic gap_en = 1'b0;

    uart_tx_arbiter #(
        .N_REQ(N),
        .D_WIDTH(DW),
        .ACK_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .grant(grant),
        .tx_ena(tx_ena),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .active_id(active_id),
        .busy(busy),
        .done(done),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: accepts a word on tx_ena and stays busy FRAME cycles.
    always @(posedge clk) begin
        if (bcnt != 0)                bcnt <= bcnt - 1;
        else if (model_en && tx_ena)  bcnt <= FRAME;
    end

    assign tx_busy = (bcnt != 0) || force_busy;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp_v
    );
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (grant != '0) begin
            g_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(grant), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("grant", 32'(grant), 32'(e.g));
                chk("grant_tx_ena", 32'(tx_ena), 1);
                chk("tx_data", 32'(tx_data), 32'(e.d));
                chk("active_id", 32'(active_id), 32'(e.id));
            end
        end
        if (tx_ena) begin
            if (gap_en && last_ena >= 0)
                chk("ena_gap_ok", 32'(cyc - last_ena >= FRAME + 3), 1);
            last_ena = cyc;
            n_ena++;
        end
        if (done) begin
            d_cyc = cyc;
            n_done++;
            chk("done_not_ack_err", 32'(ack_err), 0);
        end
        if (ack_err) begin
            a_cyc = cyc;
            n_err++;
        end
    end

    task automatic push(input int i);
        exp_t e;
        e.g  = 4'b0001 << i;
        e.d  = w[i];
        e.id = 2'(i);
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_tx_ena"}, 32'(tx_ena), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_active_id"}, 32'(active_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ack_err"}, 32'(ack_err), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals(tag);
        rst = 1'b0;
    endtask

    task automatic wait_sb(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_sb_drained"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        int n0 = n_done;
        while (n_done == n0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_done_seen"}, 32'(n_done - n0), 1);
    endtask

    task automatic wait_err(input string tag, input int budget);
        int k = 0;
        int n0 = n_err;
        while (n_err == n0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_err_seen"}, 32'(n_err - n0), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy || tx_busy) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_idle"}, 32'(busy || tx_busy), 0);
    endtask

    initial begin
        int n0, e0, drop_cyc;
        rst        = 1'b1;
        req        = '0;
        model_en   = 1'b1;
        force_busy = 1'b0;
        w[0] = 15'h1234;
        w[1] = 15'h0abc;
        w[2] = 15'h5a5a;
        w[3] = 15'h7fff;
        req_data = {w[3], w[2], w[1], w[0]};

        // Reset state
        @(negedge clk);
        do_reset("rst0");

        // Single request
        push(0);
        req = 4'b0001;
        wait_sb("single", 20);
        req = '0;
        @(negedge clk);
        #1;
        chk("single_grant_1cyc", 32'(grant), 0);
        chk("single_ena_1cyc", 32'(tx_ena), 0);
        chk("single_data_hold", 32'(tx_data), 32'h1234);
        wait_done("single", 40);
        chk("single_done_lat", 32'(d_cyc - g_cyc), FRAME + 2);
        chk("single_busy_at_done", 32'(busy), 0);
        @(negedge clk);
        #1;
        chk("single_done_1cyc", 32'(done), 0);
        chk("single_busy_after", 32'(busy), 0);

        // Contention: 1010 held from reset
        do_reset("rst1");
        push(1); push(3); push(1); push(3);
        req = 4'b1010;
        wait_sb("contend", 100);
        req = '0;
        wait_idle("contend", 40);

        // Full load
        do_reset("rst2");
        n0 = n_done;
        e0 = n_ena;
        gap_en = 1'b1;
        last_ena = -1;
        push(0); push(1); push(2); push(3); push(0);
        req = 4'b1111;
        wait_sb("full", 120);
        req = '0;
        wait_idle("full", 40);
        gap_en = 1'b0;
        chk("full_ena_count", 32'(n_ena - e0), 5);
        chk("full_done_count", 32'(n_done - n0), 5);

        // Acknowledge timeout
        model_en = 1'b0;
        n0 = n_done;
        push(2);
        req = 4'b0100;
        wait_sb("tmo", 20);
        req = '0;
        wait_err("tmo", 40);
        chk("tmo_err_lat", 32'(a_cyc - g_cyc), T + 2);
        chk("tmo_busy_low", 32'(busy), 0);
        chk("tmo_no_done", 32'(n_done - n0), 0);
        @(negedge clk);
        #1;
        chk("tmo_err_1cyc", 32'(ack_err), 0);
        model_en = 1'b1;
        push(0);
        req = 4'b0001;
        wait_sb("tmo_next", 20);
        req = '0;
        wait_done("tmo_next", 40);
        chk("tmo_next_done_lat", 32'(d_cyc - g_cyc), FRAME + 2);

        // Reset mid-frame in WAIT_DONE
        wait_idle("mid_pre", 20);
        push(0);
        req = 4'b0001;
        wait_sb("mid", 20);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_in_frame", 32'(busy && tx_busy), 1);
        n0 = n_done;
        do_reset("mid_rst");
        wait_idle("mid_post", 20);
        chk("mid_no_done", 32'(n_done - n0), 0);
        push(0); push(1);
        req = 4'b0011;
        wait_sb("mid_rr", 60);
        req = '0;
        wait_idle("mid_rr", 40);

        // Transmitter busy while IDLE
        force_busy = 1'b1;
        push(0);
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("forced_no_grant", 32'(grant), 0);
            chk("forced_no_ena", 32'(tx_ena), 0);
        end
        force_busy = 1'b0;
        drop_cyc = cyc;
        wait_sb("forced", 20);
        req = '0;
        chk("forced_grant_lat", 32'(g_cyc - drop_cyc), 1);
        wait_idle("forced", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` requesters. It sits between the client blocks and the transmitter's `tx_ena`/`tx_data`/`tx_busy` handshake. It latches one requester's word, issues a one-cycle `tx_ena`, tracks the frame through `tx_busy`, and reports completion or a missing acknowledge.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `D_WIDTH`, default 15: payload width; matches the transmitter's data width.
- `ACK_TIMEOUT`, default 4: cycles allowed in WAIT_ACK for `tx_busy` to rise; legal range ≥ 1.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in `N_REQ`: request bit per client. A client holds its bit and data until it sees its grant.
- `req_data` in `N_REQ*D_WIDTH`: client i's word is in bits [i*D_WIDTH +: D_WIDTH].
- `grant` out `N_REQ`: one-hot, registered; high for exactly one cycle when a word is accepted.
- `tx_ena` out 1: to the transmitter; registered; high for exactly one cycle per frame.
- `tx_data` out `D_WIDTH`: latched word; stable from ISSUE until the next grant.
- `tx_busy` in 1: from the transmitter.
- `active_id` out `$clog2(N_REQ)`: index of the last granted client.
- `busy` out 1: high from the grant edge until the controller returns to IDLE.
- `done` out 1: one-cycle pulse when `tx_busy` falls in WAIT_DONE.
- `ack_err` out 1: one-cycle pulse on an acknowledge timeout.

## Operation
- Reset values: `grant`=0, `tx_ena`=0, `tx_data`=0, `active_id`=0, `busy`=0, `done`=0, `ack_err`=0, state=IDLE, ack counter=0.
- The round-robin pointer `last` resets to `N_REQ-1`, so client 0 has top priority first.
- `rst` overrides all other inputs on every edge, including mid-frame. Reset never issues a pulse.
- State IDLE:
  - Grant only if `req`≠0 and `tx_busy`=0. If `tx_busy`=1, do not grant and hold requests pending.
  - Winner = the first set bit searched cyclically from `last+1` upward, wrapping at `N_REQ-1`→0.
  - On a grant: `grant`←onehot(winner), `tx_data`←word of winner, `tx_ena`←1, `active_id`←winner, `last`←winner, `busy`←1, go to ISSUE.
- State ISSUE (lasts exactly one cycle; the transmitter samples `tx_ena` at the ending edge):
  - `grant`←0, `tx_ena`←0, ack counter←0, go to WAIT_ACK.
- State WAIT_ACK:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches `ACK_TIMEOUT`: `ack_err`←1, `busy`←0, go to IDLE.
  - The word is dropped on a timeout; there is no retry. `last` has already advanced.
- State WAIT_DONE:
  - Stay while `tx_busy`=1.
  - When `tx_busy`=0: `done`←1, `busy`←0, go to IDLE.
- `done` and `ack_err` clear on the next edge and are never high together.
- The requester's `req` is ignored outside IDLE. A client that keeps `req` high after its grant is treated as a new request at the next IDLE evaluation.
- Width rule: the ack counter is `$clog2(ACK_TIMEOUT+1)` bits and never wraps.
- Unused `req_data` slices are don't-care.

## Timing
- Request latency: with `req` set and the controller in IDLE at edge e0, `grant` and `tx_ena` are high in cycle e0→e1.
- The transmitter accepts the word at edge e1 and drives `tx_busy`=1 from e1.
- The controller reaches WAIT_DONE at edge e2.
- When `tx_busy` is first seen low at edge eN, `done` is high in cycle eN→eN+1 and the state is IDLE.
- The next grant can occur at edge eN+1. The minimum gap between `tx_ena` pulses is the frame length plus 3 cycles.
- Simultaneous requests are resolved only by the round-robin order; at most one grant per frame.
- A request that rises during a frame is serviced at the first IDLE edge after that frame ends.

## Test plan
- Single request: `req`=0001, data 0x1234, transmitter model attached.
  - Required: `grant`=0001 and `tx_ena`=1 for one cycle; `tx_data`=0x1234.
  - Required: `done` one cycle after `tx_busy` falls; `busy` low afterwards.
- Contention: `req`=1010 held continuously from reset.
  - Required: grant order 0010, 1000, 0010, …; `active_id` alternates 1, 3.
- Full load: `req`=1111 held continuously.
  - Required: grants 0001, 0010, 0100, 1000, 0001.
  - Required: exactly one `tx_ena` per `done`; no two `tx_ena` pulses less than frame length plus 3 cycles apart.
- Acknowledge timeout: `tx_busy` tied 0, `req`=0100.
  - Required: `ack_err` pulses `ACK_TIMEOUT`+2 cycles after `grant`; state returns to IDLE; the next request is granted normally.
- Reset mid-frame: assert `rst` for one cycle while in WAIT_DONE.
  - Required: next cycle all outputs at reset values; no `done` pulse; after release, `req`=0011 grants client 0 first.
- Transmitter busy in IDLE: force `tx_busy`=1 with `req`=0001.
  - Required: no `grant` or `tx_ena` while forced.
  - Required: grant one edge after `tx_busy` drops.
